// File: rtl/pma_region_checker.sv
`default_nettype none
// ============================================================================
// Module   : pma_region_checker
// Purpose  : Runtime-programmable PMA region checker with a one-stage lookup
//            pipeline. Define PMA_CHECKER_ERR_LOG_EN to add first-miss capture.
// Revision : 1.0 - initial release
// ============================================================================
module pma_region_checker #(
  parameter int unsigned NumRegions = 8,
  parameter int unsigned AddrWidth  = 64,
  parameter int unsigned CntWidth   = 16
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic                          cfg_req_i,
  input  logic                          cfg_we_i,
  input  logic [$clog2(NumRegions)+1:0] cfg_addr_i,
  input  logic [AddrWidth-1:0]          cfg_wdata_i,
  output logic                          cfg_rvalid_o,
  output logic [AddrWidth-1:0]          cfg_rdata_o,
  input  logic                          req_valid_i,
  output logic                          req_ready_o,
  input  logic [AddrWidth-1:0]          req_addr_i,
  output logic                          rsp_valid_o,
  input  logic                          rsp_ready_i,
  output logic                          rsp_hit_o,
  output logic [$clog2(NumRegions)-1:0] rsp_idx_o,
  output logic [2:0]                    rsp_attr_o
);

  localparam int unsigned          c_IdxWidth = $clog2(NumRegions);
  localparam logic [7:0]           c_AttrMask = 8'h8F;
  localparam logic [CntWidth-1:0]  c_CntMax   = '1;

  logic [1:0]            w_cfgField;
  logic [c_IdxWidth-1:0] w_cfgIdx;
  logic                  w_cfgWr;
  logic                  w_cfgGlobalWr;
  logic                  w_cntClr;

  assign w_cfgField    = cfg_addr_i[1:0];
  assign w_cfgIdx      = cfg_addr_i[c_IdxWidth+1:2];
  assign w_cfgWr       = cfg_req_i && cfg_we_i;
  assign w_cfgGlobalWr = w_cfgWr && (w_cfgField == 2'd3);
  assign w_cntClr      = w_cfgGlobalWr && (w_cfgIdx == c_IdxWidth'(0));

  logic [AddrWidth-1:0]  w_regionBase [NumRegions];
  logic [AddrWidth-1:0]  w_regionLen  [NumRegions];
  logic [7:0]            w_regionAttr [NumRegions];
  logic [NumRegions-1:0] w_match;

  for (genvar gi = 0; gi < NumRegions; gi++) begin : g_region
    logic [AddrWidth-1:0] r_base;
    logic [AddrWidth-1:0] r_len;
    logic [7:0]           r_attr;
    logic [AddrWidth:0]   w_end;
    logic                 w_sel;

    // Once locked, only reset can reopen the region; the locking write itself lands.
    assign w_sel = w_cfgWr && (w_cfgIdx == c_IdxWidth'(gi)) && !r_attr[7];

    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        r_base <= '0;
        r_len  <= '0;
        r_attr <= '0;
      end else if (w_sel) begin
        case (w_cfgField)
          2'd0:    r_base <= cfg_wdata_i;
          2'd1:    r_len  <= cfg_wdata_i;
          2'd2:    r_attr <= cfg_wdata_i[7:0] & c_AttrMask;
          default: ;
        endcase
      end
    end

    // One extra bit so a region reaching the top of the address space does not wrap.
    assign w_end = {1'b0, r_base} + {1'b0, r_len};
    assign w_match[gi] = r_attr[0] && (r_len != '0) && (req_addr_i >= r_base) &&
                         ({1'b0, req_addr_i} < w_end);

    assign w_regionBase[gi] = r_base;
    assign w_regionLen[gi]  = r_len;
    assign w_regionAttr[gi] = r_attr;
  end

  logic                  w_hit;
  logic [c_IdxWidth-1:0] w_hitIdx;
  logic [2:0]            w_hitAttr;

  always_comb begin
    w_hit    = |w_match;
    w_hitIdx = '0;
    for (int i = NumRegions - 1; i >= 0; i--) begin
      if (w_match[i]) w_hitIdx = c_IdxWidth'(i);
    end
    w_hitAttr = w_hit ? w_regionAttr[w_hitIdx][3:1] : 3'b100;
  end

  logic                  r_rspValid;
  logic                  r_rspHit;
  logic [c_IdxWidth-1:0] r_rspIdx;
  logic [2:0]            r_rspAttr;
  logic                  w_reqAccept;
  logic                  w_missInc;

  assign req_ready_o = !r_rspValid || rsp_ready_i;
  assign w_reqAccept = req_valid_i && req_ready_o;
  assign w_missInc   = w_reqAccept && !w_hit;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_rspValid <= 1'b0;
      r_rspHit   <= 1'b0;
      r_rspIdx   <= '0;
      r_rspAttr  <= 3'b100;
    end else if (w_reqAccept) begin
      r_rspValid <= 1'b1;
      r_rspHit   <= w_hit;
      r_rspIdx   <= w_hitIdx;
      r_rspAttr  <= w_hitAttr;
    end else if (rsp_ready_i) begin
      r_rspValid <= 1'b0;
    end
  end

  assign rsp_valid_o = r_rspValid;
  assign rsp_hit_o   = r_rspHit;
  assign rsp_idx_o   = r_rspIdx;
  assign rsp_attr_o  = r_rspAttr;

  logic [CntWidth-1:0] r_missCnt;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_missCnt <= '0;
    end else if (w_cntClr) begin
      r_missCnt <= w_missInc ? CntWidth'(1) : '0;
    end else if (w_missInc && (r_missCnt != c_CntMax)) begin
      r_missCnt <= r_missCnt + CntWidth'(1);
    end
  end

`ifdef PMA_CHECKER_ERR_LOG_EN
  logic [AddrWidth-1:0] r_errAddr;
  logic                 r_errValid;
  logic                 w_errClr;

  assign w_errClr = w_cfgGlobalWr && (w_cfgIdx == c_IdxWidth'(2));

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_errAddr  <= '0;
      r_errValid <= 1'b0;
    end else if (w_missInc && (w_errClr || !r_errValid)) begin
      r_errAddr  <= req_addr_i;
      r_errValid <= 1'b1;
    end else if (w_errClr) begin
      r_errValid <= 1'b0;
    end
  end
`endif

  logic [AddrWidth-1:0] w_rdData;

  always_comb begin
    w_rdData = '0;
    case (w_cfgField)
      2'd0: w_rdData = w_regionBase[w_cfgIdx];
      2'd1: w_rdData = w_regionLen[w_cfgIdx];
      2'd2: w_rdData = AddrWidth'(w_regionAttr[w_cfgIdx]);
      default: begin
        if (w_cfgIdx == c_IdxWidth'(0)) w_rdData = AddrWidth'(r_missCnt);
`ifdef PMA_CHECKER_ERR_LOG_EN
        else if (w_cfgIdx == c_IdxWidth'(1)) w_rdData = r_errAddr;
        else if (w_cfgIdx == c_IdxWidth'(2)) w_rdData = AddrWidth'(r_errValid);
`endif
      end
    endcase
  end

  logic                 r_cfgRvalid;
  logic [AddrWidth-1:0] r_cfgRdata;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_cfgRvalid <= 1'b0;
      r_cfgRdata  <= '0;
    end else begin
      r_cfgRvalid <= cfg_req_i;
      if (cfg_req_i) r_cfgRdata <= cfg_we_i ? '0 : w_rdData;
    end
  end

  assign cfg_rvalid_o = r_cfgRvalid;
  assign cfg_rdata_o  = r_cfgRdata;

endmodule
`default_nettype wire
